// File: rtl/letter_queue_pkg.sv
// Shared types and defaults for the enigma-to-IR letter queue.
// DEPTH_DEF/ADDR_W_DEF also size the letter BRAM in top_level.
package letter_queue_pkg;

  localparam int LETTER_W   = 5;
  localparam int DEPTH_DEF  = 1000;
  localparam int ADDR_W_DEF = 11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } lq_state_t;

endpackage

// File: rtl/letter_queue_if.sv
// BRAM port and ir_transmitter signals seen by the queue controller.
// master = controller side, slave = BRAM/transmitter side.
interface letter_queue_if #(
  parameter int ADDR_W = letter_queue_pkg::ADDR_W_DEF
);
  import letter_queue_pkg::*;

  logic [ADDR_W-1:0]   wr_addr_out;
  logic                wr_en_out;
  logic [ADDR_W-1:0]   rd_addr_out;
  logic [LETTER_W-1:0] rd_data_in;
  logic                tx_valid_out;
  logic [LETTER_W-1:0] tx_data_out;
  logic                tx_busy_in;

  modport master (
    output wr_addr_out, wr_en_out, rd_addr_out,
    output tx_valid_out, tx_data_out,
    input  rd_data_in, tx_busy_in
  );

  modport slave (
    input  wr_addr_out, wr_en_out, rd_addr_out,
    input  tx_valid_out, tx_data_out,
    output rd_data_in, tx_busy_in
  );

endinterface

// File: rtl/letter_queue_ctrl_rise_detect.sv
// Registered rising-edge detector; pulse is combinational with sig.
module rise_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= RST_VAL;
    else     prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/letter_queue_ctrl.sv
// Letter queue controller: BRAM pointers, occupancy, one IR tx at a time.
// Optional: LETTER_QUEUE_PAUSE_EN adds pause_in to hold the FSM in IDLE.
module letter_queue_ctrl
  import letter_queue_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int READ_LATENCY = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enc_valid_in,
`ifdef LETTER_QUEUE_PAUSE_EN
  input  logic              pause_in,
`endif
  letter_queue_if.master    bus,
  output logic [ADDR_W-1:0] count_out,
  output logic              full_out,
  output logic              empty_out,
  output logic              overflow_out
);

  localparam int CNT_W = 8;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAT_END  = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0]  TO_END   = CNT_W'(BUSY_TIMEOUT - 1);

  lq_state_t state, state_nx;

  logic [ADDR_W-1:0]   wr_ptr, rd_ptr, count;
  logic [CNT_W-1:0]    cnt;
  logic [LETTER_W-1:0] tx_data;
  logic enc_rise, busy_fall, push, pop, pause;
  logic lat_done, to_done, tx_valid;

`ifdef LETTER_QUEUE_PAUSE_EN
  assign pause = pause_in;
`else
  assign pause = 1'b0;
`endif

  rise_detect u_enc_rise (
    .clk  (clk_in),
    .rst  (rst_in),
    .sig  (enc_valid_in),
    .rise (enc_rise)
  );

  // Fall of busy seen as a rise of its inverse; idle line reads as not busy.
  rise_detect #(.RST_VAL(1'b1)) u_busy_fall (
    .clk  (clk_in),
    .rst  (rst_in),
    .sig  (~bus.tx_busy_in),
    .rise (busy_fall)
  );

  assign full_out  = (count == FULL_CNT);
  assign empty_out = (count == '0);
  assign push      = enc_rise & ~full_out;
  assign pop       = (state == WAIT_DONE) & busy_fall;
  assign lat_done  = (cnt == LAT_END);
  assign to_done   = (cnt == TO_END);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
      if (enc_rise & full_out) overflow_out <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (!empty_out && !pause) state_nx = FETCH;
      FETCH:     if (lat_done) state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy_in) state_nx = WAIT_DONE;
        else if (to_done)   state_nx = ISSUE;
      end
      WAIT_DONE: if (busy_fall) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // cnt doubles as read-latency and busy-timeout counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt     <= '0;
      tx_data <= '0;
    end else begin
      unique case (state)
        IDLE:      cnt <= '0;
        FETCH: begin
          cnt <= cnt + 1'b1;
          if (lat_done) tx_data <= bus.rd_data_in;
        end
        ISSUE:     cnt <= '0;
        WAIT_BUSY: cnt <= cnt + 1'b1;
        default:   cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    unique case (state)
      ISSUE:   tx_valid = 1'b1;
      default: tx_valid = 1'b0;
    endcase
  end

  assign bus.wr_addr_out  = wr_ptr;
  assign bus.wr_en_out    = push;
  assign bus.rd_addr_out  = rd_ptr;
  assign bus.tx_valid_out = tx_valid;
  assign bus.tx_data_out  = tx_data;
  assign count_out        = count;

endmodule

// File: tb/tb_letter_queue_ctrl.sv
// Directed bench for letter_queue_ctrl with a 2-cycle BRAM model.
module tb_letter_queue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enc_valid = 1'b0;
`ifdef LETTER_QUEUE_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic [10:0] count;
  logic full, empty, overflow;
  logic [4:0] wdata = '0;
  logic [4:0] mem [0:999];
  logic [4:0] rd_q1;
  int tests = 0;
  int fails = 0;

  letter_queue_if bus ();

  letter_queue_ctrl dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .enc_valid_in (enc_valid),
`ifdef LETTER_QUEUE_PAUSE_EN
    .pause_in     (pause),
`endif
    .bus          (bus),
    .count_out    (count),
    .full_out     (full),
    .empty_out    (empty),
    .overflow_out (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.wr_en_out) mem[bus.wr_addr_out] <= wdata;
    rd_q1 <= mem[bus.rd_addr_out];
    bus.rd_data_in <= rd_q1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enc_valid = 1'b0;
    bus.tx_busy_in = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [4:0] d);
    step();
    wdata = d;
    enc_valid = 1'b1;
    step();
    enc_valid = 1'b0;
  endtask

  task automatic serve(input logic [4:0] exp_d, input logic [10:0] exp_rd,
                       input bit chk);
    bit found = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      #1;
      if (bus.tx_valid_out) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL serve_timeout no tx_valid within 40 cycles");
    end else if (chk) begin
      tests++;
      if (bus.tx_data_out !== exp_d || bus.rd_addr_out !== exp_rd) begin
        fails++;
        $display("FAIL serve_data got d=%h rd=%0d want d=%h rd=%0d",
                 bus.tx_data_out, bus.rd_addr_out, exp_d, exp_rd);
      end
    end
    step();
    bus.tx_busy_in = 1'b1;
    step();
    bus.tx_busy_in = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (count !== 11'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags got cnt=%0d e=%b f=%b o=%b want 0 1 0 0",
               count, empty, full, overflow);
    end
    tests++;
    if (bus.tx_valid_out !== 1'b0 || bus.wr_en_out !== 1'b0 || bus.tx_data_out !== 5'd0) begin
      fails++;
      $display("FAIL reset_tx got v=%b we=%b d=%h want 0 0 0",
               bus.tx_valid_out, bus.wr_en_out, bus.tx_data_out);
    end
    tests++;
    if (bus.wr_addr_out !== 11'd0 || bus.rd_addr_out !== 11'd0) begin
      fails++;
      $display("FAIL reset_ptrs got wa=%0d ra=%0d want 0 0",
               bus.wr_addr_out, bus.rd_addr_out);
    end
  endtask

  task automatic test_single();
    int wr_p = 0;
    int tx_p = 0;
    int first = -1;
    logic [4:0] txd = '0;
    logic [10:0] c54 = '0;
    step();
    wdata = 5'h13;
    enc_valid = 1'b1;
    #1;
    tests++;
    if (bus.wr_en_out !== 1'b1 || bus.wr_addr_out !== 11'd0) begin
      fails++;
      $display("FAIL single_push got we=%b wa=%0d want 1 0",
               bus.wr_en_out, bus.wr_addr_out);
    end
    wr_p = 1;
    for (int k = 1; k <= 56; k++) begin
      step();
      if (k == 5) begin
        enc_valid = 1'b0;
        bus.tx_busy_in = 1'b1;
      end
      if (k == 55) bus.tx_busy_in = 1'b0;
      #1;
      if (bus.wr_en_out) wr_p++;
      if (bus.tx_valid_out) begin
        tx_p++;
        if (first < 0) first = k;
        txd = bus.tx_data_out;
      end
      if (k == 54) c54 = count;
    end
    tests++;
    if (wr_p != 1) begin
      fails++;
      $display("FAIL single_wr_pulses got %0d want 1", wr_p);
    end
    tests++;
    if (tx_p != 1 || first != 4) begin
      fails++;
      $display("FAIL single_tx got pulses=%0d at=%0d want 1 at 4", tx_p, first);
    end
    tests++;
    if (txd !== 5'h13) begin
      fails++;
      $display("FAIL single_tx_data got %h want 13", txd);
    end
    tests++;
    if (c54 !== 11'd1) begin
      fails++;
      $display("FAIL single_inflight_count got %0d want 1", c54);
    end
    tests++;
    if (count !== 11'd0 || empty !== 1'b1 || bus.rd_addr_out !== 11'd1) begin
      fails++;
      $display("FAIL single_pop got cnt=%0d e=%b ra=%0d want 0 1 1",
               count, empty, bus.rd_addr_out);
    end
  endtask

  task automatic test_full();
    int bad = 0;
    do_reset();
    bus.tx_busy_in = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      wdata = 5'(i) ^ 5'h0A;
      enc_valid = 1'b1;
      #1;
      if (bus.wr_en_out !== 1'b1 || bus.wr_addr_out !== 11'(i)) bad++;
      step();
      enc_valid = 1'b0;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL full_fill got %0d bad pushes want 0", bad);
    end
    step();
    #1;
    tests++;
    if (count !== 11'd1000 || full !== 1'b1 || bus.wr_addr_out !== 11'd0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_state got cnt=%0d f=%b wa=%0d o=%b want 1000 1 0 0",
               count, full, bus.wr_addr_out, overflow);
    end
    tests++;
    if (bus.tx_data_out !== 5'h0A) begin
      fails++;
      $display("FAIL full_tx_data got %h want 0a", bus.tx_data_out);
    end
    step();
    enc_valid = 1'b1;
    #1;
    tests++;
    if (bus.wr_en_out !== 1'b0) begin
      fails++;
      $display("FAIL full_no_write got we=%b want 0", bus.wr_en_out);
    end
    step();
    enc_valid = 1'b0;
    #1;
    tests++;
    if (overflow !== 1'b1 || count !== 11'd1000) begin
      fails++;
      $display("FAIL full_overflow got o=%b cnt=%0d want 1 1000", overflow, count);
    end
    step();
    bus.tx_busy_in = 1'b0;
    step();
    #1;
    tests++;
    if (count !== 11'd999 || full !== 1'b0) begin
      fails++;
      $display("FAIL full_pop got cnt=%0d f=%b want 999 0", count, full);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] d3 [3];
    logic [10:0] a3 [3];
    d3[0] = 5'h11; d3[1] = 5'h12; d3[2] = 5'h14;
    a3[0] = 11'd998; a3[1] = 11'd999; a3[2] = 11'd0;
    do_reset();
    for (int n = 0; n < 998; n++) begin
      push(5'(n));
      serve(5'd0, 11'd0, 1'b0);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          step();
          wdata = d3[i];
          enc_valid = 1'b1;
          #1;
          tests++;
          if (bus.wr_en_out !== 1'b1 || bus.wr_addr_out !== a3[i]) begin
            fails++;
            $display("FAIL wrap_push%0d got we=%b wa=%0d want 1 %0d",
                     i, bus.wr_en_out, bus.wr_addr_out, a3[i]);
          end
          step();
          enc_valid = 1'b0;
        end
      end
      begin
        for (int i = 0; i < 3; i++) serve(d3[i], a3[i], 1'b1);
      end
    join
    #1;
    tests++;
    if (count !== 11'd0 || bus.rd_addr_out !== 11'd1) begin
      fails++;
      $display("FAIL wrap_end got cnt=%0d ra=%0d want 0 1", count, bus.rd_addr_out);
    end
  endtask

  task automatic test_simul();
    bus.tx_busy_in = 1'b1;
    push(5'h05);
    push(5'h06);
    for (int k = 0; k < 5; k++) step();
    #1;
    tests++;
    if (count !== 11'd2 || bus.wr_addr_out !== 11'd3 || bus.rd_addr_out !== 11'd1
        || bus.tx_data_out !== 5'h05) begin
      fails++;
      $display("FAIL simul_pre got cnt=%0d wa=%0d ra=%0d d=%h want 2 3 1 05",
               count, bus.wr_addr_out, bus.rd_addr_out, bus.tx_data_out);
    end
    step();
    bus.tx_busy_in = 1'b0;
    wdata = 5'h07;
    enc_valid = 1'b1;
    #1;
    tests++;
    if (bus.wr_en_out !== 1'b1) begin
      fails++;
      $display("FAIL simul_wr_en got %b want 1", bus.wr_en_out);
    end
    step();
    enc_valid = 1'b0;
    #1;
    tests++;
    if (count !== 11'd2 || bus.wr_addr_out !== 11'd4 || bus.rd_addr_out !== 11'd2) begin
      fails++;
      $display("FAIL simul_post got cnt=%0d wa=%0d ra=%0d want 2 4 2",
               count, bus.wr_addr_out, bus.rd_addr_out);
    end
  endtask

  task automatic test_timeout();
    int p [3];
    int np = 0;
    int bad = 0;
    do_reset();
    push(5'h1C);
    for (int k = 1; k <= 60; k++) begin
      step();
      #1;
      if (bus.tx_valid_out) begin
        if (np < 3) p[np] = k;
        np++;
        if (bus.tx_data_out !== 5'h1C) bad++;
      end
    end
    tests++;
    if (np < 3) begin
      fails++;
      $display("FAIL timeout_pulses got %0d want >=3", np);
    end else if (p[1] - p[0] != 17 || p[2] - p[1] != 17) begin
      fails++;
      $display("FAIL timeout_period got %0d %0d want 17 17", p[1] - p[0], p[2] - p[1]);
    end
    tests++;
    if (bad != 0 || count !== 11'd1) begin
      fails++;
      $display("FAIL timeout_data got bad=%0d cnt=%0d want 0 1", bad, count);
    end
  endtask

  task automatic test_reset_mid();
    int tx_p = 0;
    do_reset();
    bus.tx_busy_in = 1'b1;
    push(5'h09);
    for (int k = 0; k < 8; k++) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (count !== 11'd0 || empty !== 1'b1 || bus.tx_valid_out !== 1'b0
        || bus.rd_addr_out !== 11'd0) begin
      fails++;
      $display("FAIL rstmid_state got cnt=%0d e=%b v=%b ra=%0d want 0 1 0 0",
               count, empty, bus.tx_valid_out, bus.rd_addr_out);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      #1;
      if (bus.tx_valid_out) tx_p++;
    end
    bus.tx_busy_in = 1'b0;
    tests++;
    if (tx_p != 0) begin
      fails++;
      $display("FAIL rstmid_idle got %0d tx pulses want 0", tx_p);
    end
    push(5'h15);
    serve(5'h15, 11'd0, 1'b1);
  endtask

`ifdef LETTER_QUEUE_PAUSE_EN
  task automatic test_pause();
    int tx_p = 0;
    do_reset();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      wdata = 5'(i + 1);
      enc_valid = 1'b1;
      #1;
      if (bus.tx_valid_out) tx_p++;
      step();
      enc_valid = 1'b0;
      #1;
      if (bus.tx_valid_out) tx_p++;
    end
    for (int k = 0; k < 12; k++) begin
      step();
      #1;
      if (bus.tx_valid_out) tx_p++;
    end
    tests++;
    if (tx_p != 0 || count !== 11'd3) begin
      fails++;
      $display("FAIL pause_hold got tx=%0d cnt=%0d want 0 3", tx_p, count);
    end
    pause = 1'b0;
    for (int i = 0; i < 3; i++) serve(5'(i + 1), 11'(i), 1'b1);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.tx_busy_in = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_simul();
    test_timeout();
    test_reset_mid();
`ifdef LETTER_QUEUE_PAUSE_EN
    test_pause();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
